// File: rtl/any1_pkg.sv
// Shared ANY-1 core types and constants: reorder-buffer sizing, rid type,
// reorder-entry record and fault-cause helpers.
package any1_pkg;

  localparam int AWID      = 64;
  localparam int ROB_DWID  = 64;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_RIDW  = $clog2(ROB_DEPTH);

  localparam logic [15:0] CAUSE_NONE = 16'h0;

  typedef logic [ROB_RIDW-1:0] rid_t;

  typedef struct packed {
    logic                v;
    logic                cmt;
    logic [AWID-1:0]     ip;
    logic                rfwr;
    logic [7:0]          rt;
    logic [ROB_DWID-1:0] res;
    logic [15:0]         cause;
    logic                jump;
    logic [ROB_DWID-1:0] jump_tgt;
    logic                takb;
  } sReorderEntry;

  function automatic logic is_fault(input logic [15:0] cause);
    return cause != CAUSE_NONE;
  endfunction

endpackage

// File: rtl/any1_rob_fwd_search.sv
// Youngest-first register match over the reorder buffer; valid bits bound
// the live window, so only entries between head and tail can match.
module any1_rob_fwd_search #(
  parameter int DEPTH = 16,
  parameter int RIDW  = $clog2(DEPTH),
  parameter int DWID  = 64
) (
  input  logic [DEPTH-1:0]           v_i,
  input  logic [DEPTH-1:0]           rfwr_i,
  input  logic [DEPTH-1:0]           cmt_i,
  input  logic [DEPTH-1:0][7:0]      rt_i,
  input  logic [DEPTH-1:0][DWID-1:0] res_i,
  input  logic [RIDW-1:0]            tail_i,
  input  logic [7:0]                 reg_i,
  output logic                       hit_o,
  output logic                       rdy_o,
  output logic [DWID-1:0]            res_o
);

  logic [RIDW-1:0] idx;

  // Walk oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    hit_o = 1'b0;
    rdy_o = 1'b0;
    res_o = '0;
    idx   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail_i - RIDW'(1) - RIDW'(k);
      if (reg_i != 8'd0 && v_i[idx] && rfwr_i[idx] && rt_i[idx] == reg_i) begin
        hit_o = 1'b1;
        rdy_o = cmt_i[idx];
        res_o = res_i[idx];
      end
    end
  end

endmodule

// File: rtl/any1_reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete by rid,
// in-order retire with exception flush. ANY1_ROB_FWD_EN adds result forwarding.
module any1_reorder_buffer
  import any1_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int RIDW  = $clog2(DEPTH),
  parameter int DWID  = ROB_DWID
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            alloc_v_i,
  input  logic [AWID-1:0] alloc_ip_i,
  input  logic            alloc_rfwr_i,
  input  logic [7:0]      alloc_rt_i,
  output logic            alloc_rdy_o,
  output logic [RIDW-1:0] alloc_rid_o,
  input  logic            cmpl_v_i,
  input  logic [RIDW-1:0] cmpl_rid_i,
  input  logic [DWID-1:0] cmpl_res_i,
  input  logic [15:0]     cmpl_cause_i,
  input  logic            cmpl_jump_i,
  input  logic [DWID-1:0] cmpl_tgt_i,
  input  logic            cmpl_takb_i,
  output logic            cmt_v_o,
  output logic [AWID-1:0] cmt_ip_o,
  output logic            cmt_rfwr_o,
  output logic [7:0]      cmt_rt_o,
  output logic [DWID-1:0] cmt_res_o,
  output logic            cmt_exc_o,
  output logic [15:0]     cmt_cause_o,
`ifdef ANY1_ROB_FWD_EN
  input  logic [7:0]      fwd_reg_i,
  output logic            fwd_hit_o,
  output logic            fwd_rdy_o,
  output logic [DWID-1:0] fwd_res_o,
`endif
  output logic [RIDW:0]   count_o,
  output logic            empty_o
);

  localparam logic [RIDW:0] FULL_CNT = (RIDW+1)'(DEPTH);

  logic [RIDW-1:0] head, tail;
  logic [RIDW:0]   count;

  logic [DEPTH-1:0]            ent_v, ent_cmt;
  logic [DEPTH-1:0]            ent_rfwr, ent_jump, ent_takb;
  logic [DEPTH-1:0][AWID-1:0]  ent_ip;
  logic [DEPTH-1:0][7:0]       ent_rt;
  logic [DEPTH-1:0][DWID-1:0]  ent_res, ent_tgt;
  logic [DEPTH-1:0][15:0]      ent_cause;

  logic alloc_fire, cmpl_fire, ret_fire, ret_exc;

  // Readiness uses registered count only: a retire never frees a slot in the same cycle.
  assign alloc_rdy_o = count < FULL_CNT;
  assign alloc_rid_o = tail;
  assign count_o     = count;
  assign empty_o     = count == '0;

  assign alloc_fire = alloc_v_i && alloc_rdy_o;
  assign cmpl_fire  = cmpl_v_i && ent_v[cmpl_rid_i];
  assign ret_fire   = ent_v[head] && ent_cmt[head];
  assign ret_exc    = ret_fire && is_fault(ent_cause[head]);

  // Entry payload: written on allocate/complete, never reset.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      ent_ip[tail]    <= alloc_ip_i;
      ent_rfwr[tail]  <= alloc_rfwr_i;
      ent_rt[tail]    <= alloc_rt_i;
      ent_cause[tail] <= CAUSE_NONE;
    end
    if (cmpl_fire) begin
      ent_res[cmpl_rid_i]   <= cmpl_res_i;
      ent_cause[cmpl_rid_i] <= cmpl_cause_i;
      ent_jump[cmpl_rid_i]  <= cmpl_jump_i;
      ent_tgt[cmpl_rid_i]   <= cmpl_tgt_i;
      ent_takb[cmpl_rid_i]  <= cmpl_takb_i;
    end
  end

  // Pointers, occupancy, entry state bits and the registered retire port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ent_v       <= '0;
      ent_cmt     <= '0;
      cmt_v_o     <= 1'b0;
      cmt_ip_o    <= '0;
      cmt_rfwr_o  <= 1'b0;
      cmt_rt_o    <= '0;
      cmt_res_o   <= '0;
      cmt_exc_o   <= 1'b0;
      cmt_cause_o <= '0;
    end else if (flush_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_v   <= '0;
      ent_cmt <= '0;
      cmt_v_o <= 1'b0;
    end else begin
      cmt_v_o <= ret_fire;
      if (ret_fire) begin
        cmt_ip_o    <= ent_ip[head];
        cmt_rt_o    <= ent_rt[head];
        cmt_res_o   <= ent_res[head];
        cmt_exc_o   <= ret_exc;
        cmt_cause_o <= ent_cause[head];
        cmt_rfwr_o  <= ent_rfwr[head] && !ret_exc;
      end
      if (ret_exc) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        ent_v   <= '0;
        ent_cmt <= '0;
      end else begin
        if (alloc_fire) begin
          ent_v[tail]   <= 1'b1;
          ent_cmt[tail] <= 1'b0;
          tail          <= tail + RIDW'(1);
        end
        if (cmpl_fire)
          ent_cmt[cmpl_rid_i] <= 1'b1;
        // Retire last so it overrides a same-cycle repeat completion of head.
        if (ret_fire) begin
          ent_v[head]   <= 1'b0;
          ent_cmt[head] <= 1'b0;
          head          <= head + RIDW'(1);
        end
        count <= count + (RIDW+1)'(alloc_fire) - (RIDW+1)'(ret_fire);
      end
    end
  end

`ifdef ANY1_ROB_FWD_EN
  any1_rob_fwd_search #(
    .DEPTH (DEPTH),
    .RIDW  (RIDW),
    .DWID  (DWID)
  ) u_fwd_search (
    .v_i    (ent_v),
    .rfwr_i (ent_rfwr),
    .cmt_i  (ent_cmt),
    .rt_i   (ent_rt),
    .res_i  (ent_res),
    .tail_i (tail),
    .reg_i  (fwd_reg_i),
    .hit_o  (fwd_hit_o),
    .rdy_o  (fwd_rdy_o),
    .res_o  (fwd_res_o)
  );
`endif

endmodule

// File: doc/any1_reorder_buffer.md
Name: any1_reorder_buffer

Overview:
- Parametrised circular reorder buffer for the ANY-1 core, built on the package reorder-entry record.
- Sits between decode/dispatch and register-file writeback.
- Allocates entries in program order, accepts out-of-order completions by rid, and retires in order, one entry per cycle.
- Generalises the fixed 16-entry, 4-bit rid record to any power-of-two depth and adds an exception/flush path.

Parameters:
DEPTH, 16, number of entries; power of two, 4..64
RIDW, $clog2(DEPTH), rid width
DWID, 64, result/jump-target width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  external flush (branch mispredict); clears all entries
alloc_v_i  in  1  dispatch request
alloc_ip_i  in  AWID  instruction pointer
alloc_rfwr_i  in  1  entry writes the register file
alloc_rt_i  in  8  target register
alloc_rdy_o  out  1  entry available (count<DEPTH)
alloc_rid_o  out  RIDW  rid granted (= tail)
cmpl_v_i  in  1  completion strobe
cmpl_rid_i  in  RIDW  completing entry
cmpl_res_i  in  DWID  result
cmpl_cause_i  in  16  fault cause, 0 = none
cmpl_jump_i  in  1  jump taken
cmpl_tgt_i  in  DWID  jump target
cmpl_takb_i  in  1  branch taken
cmt_v_o  out  1  retire valid (registered)
cmt_ip_o  out  AWID  retired ip
cmt_rfwr_o  out  1  write register file
cmt_rt_o  out  8  target register
cmt_res_o  out  DWID  result
cmt_exc_o  out  1  retired entry faulted
cmt_cause_o  out  16  fault cause
count_o  out  RIDW+1  occupied entries
empty_o  out  1  count==0

Behaviour:
- Reset (rst_i on a clock edge): head=tail=count=0; all v/cmt cleared; all cmt_* outputs 0; empty_o=1; alloc_rdy_o=1.
- alloc_rdy_o and alloc_rid_o are combinational from registered state.
- Allocation: when alloc_v_i && alloc_rdy_o:
  - entry[tail] gets v=1, cmt=0, ip, rfwr, Rt, cause=0.
  - tail = tail+1 modulo DEPTH, with natural RIDW-bit wrap.
  - alloc_v_i while full is ignored; no state change.
- Completion: when cmpl_v_i && entry[cmpl_rid_i].v:
  - Writes res, cause, jump, jump_tgt, takb, and sets cmt=1.
  - Completion to an invalid entry is ignored.
  - Repeat completion overwrites the earlier values.
- Retire: each cycle, if entry[head].v && entry[head].cmt:
  - Next cycle cmt_v_o=1 with the head fields.
  - head advances and entry[head].v is cleared.
  - Otherwise cmt_v_o=0; the other cmt_* outputs hold their last values.
  - Latency: completion at edge N gives earliest cmt_v_o after edge N+1.
- Exception: if the retiring entry has cause!=0:
  - cmt_exc_o=1, cmt_cause_o=cause, cmt_rfwr_o forced 0.
  - In the same edge all entries are invalidated and head=tail=count=0.
- Count: count += alloc − retire; simultaneous alloc and retire leaves count unchanged.
- Full boundary: alloc_rdy_o=0 while count==DEPTH, even if a retire occurs the same cycle (no same-cycle reuse).
- Completion to head in the same cycle head is evaluated: the completion is seen; retire occurs next cycle.
- Priority: rst_i > flush_i > exception-flush > retire/alloc/complete.
- flush_i: invalidates all entries, head=tail=count=0; cmt_v_o=0 next cycle, with no retire in that cycle.
- Reset or flush mid-operation discards pending completions; a late cmpl_v_i to a now-invalid rid is ignored.

Optional Feature:
- Macro: ANY1_ROB_FWD_EN.
- When defined, adds fwd_reg_i (in 8), fwd_hit_o (out 1), fwd_rdy_o (out 1) and fwd_res_o (out DWID).
  - Combinational search of valid entries, youngest to oldest from tail−1 back to head, wrap-aware.
  - Matches the first entry with rfwr && Rt==fwd_reg_i.
  - fwd_hit_o=1 on a match; fwd_rdy_o=entry.cmt; fwd_res_o=entry.res.
  - fwd_reg_i==0 never hits.
- When undefined, the ports are absent and no search logic is built.

Decomposition:
- any1_pkg gains:
  - ROB_DEPTH and ROB_RIDW constants.
  - A rid typedef sized by ROB_RIDW.
  - sReorderEntry extended with takb/jump/jump_tgt widths tied to DWID.
  - A CAUSE_NONE=16'h0 constant.
- One sub-module is natural: any1_rob_fwd_search, a youngest-match priority finder used under ANY1_ROB_FWD_EN.

Test Plan:
- Reset, then alloc 3 entries (ip 0x100/0x108/0x110) → rids 0,1,2; count_o=3; empty_o=0.
- Complete rid2 then rid0 (res 0xAA, 0xBB) → retire rid0 only (cmt_res_o=0xBB); rid1 incomplete blocks; complete rid1 → rid1, rid2 retire on consecutive cycles.
- Fill 16 entries → alloc_rdy_o=0; 17th alloc ignored; retire one with simultaneous alloc request → refused that cycle, accepted next with rid 0 (wrap).
- Complete the head with cause 0x37 → cmt_exc_o=1, cmt_cause_o=0x37, cmt_rfwr_o=0; next cycle count_o=0, empty_o=1.
- flush_i asserted together with alloc_v_i and cmpl_v_i → count_o=0, no cmt_v_o, later completion to an old rid ignored.
- FWD_EN: rids 0 and 3 both target r5, rid3 completed with 0x55 → fwd_hit_o=1, fwd_rdy_o=1, fwd_res_o=0x55; fwd_reg_i=0 → fwd_hit_o=0.
